ide_host_master: RTL and testbench
==================================

IDE_HOST_MASTER -- requirements
Module: ide_host_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 2: clocks from address/chip-select valid to strobe assertion (min 1).
REQ-002 SHALL have parameter T_ACTIVE, default 4: minimum clocks the strobe is held low (min 1).
REQ-003 SHALL have parameter T_RECOVER, default 3: clocks with chip selects negated after a cycle (min 1).
REQ-004 SHALL have parameter T_TIMEOUT, default 16: maximum clocks spent waiting on IORDY (min 1).
REQ-005 SHALL have one clock, `clk  in  1`; all logic on its rising edge.
REQ-006 SHALL have `reset_  in  1`; reset is asynchronous and active-low.
REQ-007 req  in  1  — starts a register access when sampled high in IDLE.
REQ-008 wr  in  1  — 1 = write, 0 = read; latched with req.
REQ-009 cs3  in  1  — 1 = control block (cs3fx_), 0 = command block (cs1fx_); latched with req.
REQ-010 addr  in  3  — register address; latched with req.
REQ-011 wdata  in  16  — write data; latched with req.
REQ-012 busy  out  1  — access in progress.
REQ-013 done  out  1  — single-cycle completion pulse.
REQ-014 rdata  out  16  — read result; held until the next read completes.
REQ-015 timeout  out  1  — status of the last access; 1 = IORDY wait expired.
REQ-016 intrq_s  out  1  — two-flop synchronised intrq.
REQ-017 Bus outputs: da out 3, cs1fx_ out 1, cs3fx_ out 1, dior_ out 1, diow_ out 1, dmack_ out 1.
REQ-018 dd_out out 16 with dd_oe out 1 is the data-bus drive; dd_in in 16 is the data-bus sample.
REQ-019 iordy in 1 and intrq in 1 are asynchronous bus inputs.

Function
REQ-020 FSM states: IDLE, SETUP, ACTIVE, WAIT_RDY, HOLD, RECOVER; one down-counter is shared by all timed states.
REQ-021 IDLE with req=1, on edge E0:
- latch wr, cs3, addr, wdata;
- drive da = addr, and assert cs3fx_ = 0 if cs3 else cs1fx_ = 0;
- if wr, dd_out = wdata and dd_oe = 1;
- busy = 1; go to SETUP.
REQ-022 SETUP lasts T_SETUP clocks, then enters ACTIVE with dior_ = 0 (read) or diow_ = 0 (write).
REQ-023 ACTIVE lasts T_ACTIVE clocks. At expiry: if the synchronised iordy is 1, go to HOLD; otherwise go to WAIT_RDY.
REQ-024 WAIT_RDY:
- If the synchronised iordy is 1, go to HOLD.
- After T_TIMEOUT clocks without it, set timeout = 1 and go to HOLD.
REQ-025 On entry to HOLD the strobe is negated. On a read, rdata captures dd_in on that same edge.
REQ-026 Read width: if cs3 = 0 and addr = 0, rdata = dd_in[15:0]; otherwise rdata = {8'h00, dd_in[7:0]}.
REQ-027 HOLD lasts 1 clock with da, chip select and dd_oe unchanged, then enters RECOVER with cs1fx_ = cs3fx_ = 1 and dd_oe = 0.
REQ-028 RECOVER lasts T_RECOVER clocks, then goes to IDLE with done = 1 for one clock and busy = 0 on the same edge.
REQ-029 Latency without IORDY wait: done is high in the cycle after edge E0 + (T_SETUP + T_ACTIVE + 1 + T_RECOVER).
REQ-030 req while busy = 1 SHALL be ignored and not queued.
REQ-031 req held high continuously SHALL start a new access on the clock after done.
REQ-032 timeout SHALL be cleared at E0 of each new access.
REQ-033 dior_ and diow_ SHALL never be low simultaneously.
REQ-034 dmack_ SHALL be constant 1 (no DMA in this block).
REQ-035 iordy SHALL pass through a two-flop synchroniser before use; iordy low before ACTIVE expiry SHALL have no effect.
REQ-036 Counter SHALL be wide enough for max(T_*) with no wrap-around.

Reset
REQ-037 reset_ = 0 SHALL asynchronously force:
- state = IDLE;
- da = 0; cs1fx_, cs3fx_, dior_, diow_, dmack_ = 1;
- dd_oe = 0; dd_out = 0;
- busy, done, timeout = 0;
- rdata = 0; intrq_s = 0; synchroniser flops = 0.
REQ-038 Reset mid-access SHALL abort the access immediately with no done pulse.
REQ-039 After reset_ rises, the first req SHALL be accepted on the first rising edge.

Verification
REQ-040 Read, defaults, cs3 = 0, addr = 7, iordy = 1, dd_in = 16'h1250:
- cs1fx_ low for 7 clocks; dior_ low for exactly 4;
- rdata = 16'h0050; done in the cycle after E0 + 10.
REQ-041 Write, cs3 = 1, addr = 6, wdata = 16'h0004:
- dd_oe high from E0 through HOLD; dd_out = 16'h0004;
- diow_ low for 4 clocks; cs3fx_ low, cs1fx_ high throughout.
REQ-042 Data read, addr = 0, cs3 = 0, iordy low for 5 clocks after ACTIVE expiry:
- dior_ stretched by 5 clocks; rdata = full dd_in; timeout = 0; done 5 clocks later than REQ-040.
REQ-043 iordy held low:
- dior_ negated after 4 + 16 clocks; timeout = 1, done = 1;
- next access clears timeout at its E0.
REQ-044 req pulsed during SETUP and RECOVER -> ignored, one done only. reset_ = 0 during ACTIVE -> dior_ = 1, busy = 0 immediately, no done.
REQ-045 intrq toggled -> intrq_s follows after 2 clocks.

Source files
------------

// File: rtl/ide_host_master.sv
// PIO register-access master for an ATA/IDE device: sequences chip select, strobe,
// IORDY wait and recovery for one 8/16-bit register read or write per request.
module ide_host_master #(
  parameter int T_SETUP   = 2,
  parameter int T_ACTIVE  = 4,
  parameter int T_RECOVER = 3,
  parameter int T_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        req,
  input  logic        wr,
  input  logic        cs3,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        timeout,
  output logic        intrq_s,
  output logic [2:0]  da,
  output logic        cs1fx_,
  output logic        cs3fx_,
  output logic        dior_,
  output logic        diow_,
  output logic        dmack_,
  output logic [15:0] dd_out,
  output logic        dd_oe,
  input  logic [15:0] dd_in,
  input  logic        iordy,
  input  logic        intrq
);

  localparam int T_MAX_SA = (T_SETUP > T_ACTIVE) ? T_SETUP : T_ACTIVE;
  localparam int T_MAX_RT = (T_RECOVER > T_TIMEOUT) ? T_RECOVER : T_TIMEOUT;
  localparam int T_MAX    = (T_MAX_SA > T_MAX_RT) ? T_MAX_SA : T_MAX_RT;
  localparam int CW       = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LOAD_SETUP   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LOAD_ACTIVE  = CW'(T_ACTIVE - 1);
  localparam logic [CW-1:0] LOAD_RECOVER = CW'(T_RECOVER - 1);
  localparam logic [CW-1:0] LOAD_TIMEOUT = CW'(T_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    WAIT_RDY,
    HOLD,
    RECOVER
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          wr_reg, wr_next;
  logic          cs3_reg, cs3_next;
  logic [2:0]    da_reg, da_next;
  logic          cs1_n_reg, cs1_n_next;
  logic          cs3_n_reg, cs3_n_next;
  logic          dior_n_reg, dior_n_next;
  logic          diow_n_reg, diow_n_next;
  logic [15:0]   dd_out_reg, dd_out_next;
  logic          dd_oe_reg, dd_oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          timeout_reg, timeout_next;
  logic [15:0]   rdata_reg, rdata_next;
  logic          iordy_meta_reg, iordy_s_reg;
  logic          intrq_meta_reg, intrq_s_reg;
  logic          go_hold;
  logic          cnt_zero;

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      iordy_meta_reg <= 1'b0;
      iordy_s_reg    <= 1'b0;
      intrq_meta_reg <= 1'b0;
      intrq_s_reg    <= 1'b0;
    end else begin
      iordy_meta_reg <= iordy;
      iordy_s_reg    <= iordy_meta_reg;
      intrq_meta_reg <= intrq;
      intrq_s_reg    <= intrq_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_reg      <= 1'b0;
      cs3_reg     <= 1'b0;
      da_reg      <= 3'd0;
      cs1_n_reg   <= 1'b1;
      cs3_n_reg   <= 1'b1;
      dior_n_reg  <= 1'b1;
      diow_n_reg  <= 1'b1;
      dd_out_reg  <= 16'h0000;
      dd_oe_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      rdata_reg   <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_reg      <= wr_next;
      cs3_reg     <= cs3_next;
      da_reg      <= da_next;
      cs1_n_reg   <= cs1_n_next;
      cs3_n_reg   <= cs3_n_next;
      dior_n_reg  <= dior_n_next;
      diow_n_reg  <= diow_n_next;
      dd_out_reg  <= dd_out_next;
      dd_oe_reg   <= dd_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_next      = wr_reg;
    cs3_next     = cs3_reg;
    da_next      = da_reg;
    cs1_n_next   = cs1_n_reg;
    cs3_n_next   = cs3_n_reg;
    dior_n_next  = dior_n_reg;
    diow_n_next  = diow_n_reg;
    dd_out_next  = dd_out_reg;
    dd_oe_next   = dd_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    timeout_next = timeout_reg;
    rdata_next   = rdata_reg;
    go_hold      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req) begin
          wr_next      = wr;
          cs3_next     = cs3;
          da_next      = addr;
          cs1_n_next   = cs3;
          cs3_n_next   = ~cs3;
          if (wr) begin
            dd_out_next = wdata;
            dd_oe_next  = 1'b1;
          end
          busy_next    = 1'b1;
          timeout_next = 1'b0;
          cnt_next     = LOAD_SETUP;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          // Exactly one strobe goes low, chosen by the latched direction.
          dior_n_next = wr_reg;
          diow_n_next = ~wr_reg;
          cnt_next    = LOAD_ACTIVE;
          state_next  = ACTIVE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ACTIVE: begin
        if (cnt_zero) begin
          if (iordy_s_reg) begin
            go_hold = 1'b1;
          end else begin
            cnt_next   = LOAD_TIMEOUT;
            state_next = WAIT_RDY;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WAIT_RDY: begin
        if (iordy_s_reg) begin
          go_hold = 1'b1;
        end else if (cnt_zero) begin
          timeout_next = 1'b1;
          go_hold      = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      HOLD: begin
        cs1_n_next = 1'b1;
        cs3_n_next = 1'b1;
        dd_oe_next = 1'b0;
        cnt_next   = LOAD_RECOVER;
        state_next = RECOVER;
      end
      RECOVER: begin
        if (cnt_zero) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Strobe release and read capture share one edge so the device data is still valid.
    if (go_hold) begin
      dior_n_next = 1'b1;
      diow_n_next = 1'b1;
      state_next  = HOLD;
      if (!wr_reg) begin
        rdata_next = (!cs3_reg && da_reg == 3'd0) ? dd_in : {8'h00, dd_in[7:0]};
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rdata   = rdata_reg;
  assign timeout = timeout_reg;
  assign intrq_s = intrq_s_reg;
  assign da      = da_reg;
  assign cs1fx_  = cs1_n_reg;
  assign cs3fx_  = cs3_n_reg;
  assign dior_   = dior_n_reg;
  assign diow_   = diow_n_reg;
  assign dmack_  = 1'b1;
  assign dd_out  = dd_out_reg;
  assign dd_oe   = dd_oe_reg;

endmodule

// File: tb/tb_ide_host_master.sv
// Scoreboard bench for ide_host_master: drivers push expected completions,
// a negedge monitor measures bus activity and checks each done pulse.
module tb_ide_host_master;

  localparam int T_SETUP   = 2;
  localparam int T_ACTIVE  = 4;
  localparam int T_RECOVER = 3;
  localparam int T_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        cs3 = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] dd_in = 16'h0000;
  logic        iordy = 1'b1;
  logic        intrq = 1'b0;

  logic        busy, done, timeout, intrq_s;
  logic [15:0] rdata, dd_out;
  logic [2:0]  da;
  logic        cs1fx_, cs3fx_, dior_, diow_, dmack_, dd_oe;

  ide_host_master #(
    .T_SETUP(T_SETUP), .T_ACTIVE(T_ACTIVE), .T_RECOVER(T_RECOVER), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk(clk), .reset_(reset_), .req(req), .wr(wr), .cs3(cs3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .timeout(timeout), .intrq_s(intrq_s),
    .da(da), .cs1fx_(cs1fx_), .cs3fx_(cs3fx_), .dior_(dior_), .diow_(diow_), .dmack_(dmack_),
    .dd_out(dd_out), .dd_oe(dd_oe), .dd_in(dd_in), .iordy(iordy), .intrq(intrq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        timeout;
    int          done_cyc;
    int          cs1_low;
    int          cs3_low;
    int          rd_low;
    int          wr_low;
    int          oe_high;
    logic [2:0]  da;
    logic [15:0] dd_out;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // lat = edges from E0 to the edge that raises done; cs held for lat - T_RECOVER clocks.
  function automatic exp_t mk(input logic w, input logic c3, input logic [2:0] a,
                              input logic [15:0] wd, input logic [15:0] exp_rd,
                              input logic exp_to, input int lat);
    exp_t e;
    int cs_clk;
    cs_clk     = lat - T_RECOVER;
    e.rdata    = exp_rd;
    e.timeout  = exp_to;
    e.done_cyc = cyc + 1 + lat;
    e.cs1_low  = c3 ? 0 : cs_clk;
    e.cs3_low  = c3 ? cs_clk : 0;
    e.rd_low   = w ? 0 : cs_clk - T_SETUP - 1;
    e.wr_low   = w ? cs_clk - T_SETUP - 1 : 0;
    e.oe_high  = w ? cs_clk : 0;
    e.da       = a;
    e.dd_out   = wd;
    return e;
  endfunction

  // Monitor: accumulates bus activity between done pulses.
  int n_cs1 = 0, n_cs3 = 0, n_rd = 0, n_wr = 0, n_oe = 0, txn = 0;
  logic [2:0]  seen_da = 3'd0;
  logic [15:0] seen_dd = 16'h0000;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset_) begin
      n_cs1 = 0; n_cs3 = 0; n_rd = 0; n_wr = 0; n_oe = 0;
    end else begin
      if (!cs1fx_) n_cs1++;
      if (!cs3fx_) n_cs3++;
      if (!dior_)  n_rd++;
      if (!diow_)  n_wr++;
      if (dd_oe) begin
        n_oe++;
        seen_dd = dd_out;
      end
      if (!cs1fx_ || !cs3fx_) seen_da = da;
      if (!dior_ && !diow_) begin
        miscompares++;
        $display("FAIL strobe_overlap: dior_=%b diow_=%b, expected never both 0 (cycle %0d)", dior_, diow_, cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 with no access pending (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          txn++;
          check("rdata",    rdata,   mon_e.rdata);
          check("timeout",  timeout, mon_e.timeout);
          check("done_cyc", cyc,     mon_e.done_cyc);
          check("busy_at_done", busy, 0);
          check("cs1_low",  n_cs1,   mon_e.cs1_low);
          check("cs3_low",  n_cs3,   mon_e.cs3_low);
          check("dior_low", n_rd,    mon_e.rd_low);
          check("diow_low", n_wr,    mon_e.wr_low);
          check("oe_high",  n_oe,    mon_e.oe_high);
          check("da",       seen_da, mon_e.da);
          if (mon_e.oe_high > 0) check("dd_out", seen_dd, mon_e.dd_out);
          $display("txn %0d: done at cycle %0d rdata=%h timeout=%b cs1/cs3/dior/diow/oe=%0d/%0d/%0d/%0d/%0d",
                   txn, cyc, rdata, timeout, n_cs1, n_cs3, n_rd, n_wr, n_oe);
        end
        n_cs1 = 0; n_cs3 = 0; n_rd = 0; n_wr = 0; n_oe = 0;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still 1 after 200 cycles (cycle %0d)", cyc);
    end
  endtask

  // Called at a negedge; the following rising edge is E0.
  task automatic do_access(input logic w, input logic c3, input logic [2:0] a,
                           input logic [15:0] wd, input logic [15:0] din,
                           input logic [15:0] exp_rd, input logic exp_to, input int lat);
    wr = w; cs3 = c3; addr = a; wdata = wd; dd_in = din; req = 1'b1;
    sb.push_back(mk(w, c3, a, wd, exp_rd, exp_to, lat));
    @(negedge clk);
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got_done;
    #1 reset_ = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rdata", rdata, 0);
    check("rst_da", da, 0);
    check("rst_cs1fx_", cs1fx_, 1);
    check("rst_cs3fx_", cs3fx_, 1);
    check("rst_dior_", dior_, 1);
    check("rst_diow_", diow_, 1);
    check("rst_dmack_", dmack_, 1);
    check("rst_dd_oe", dd_oe, 0);
    check("rst_dd_out", dd_out, 0);
    check("rst_intrq_s", intrq_s, 0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    repeat (3) @(negedge clk);

    // Register read, 8-bit result, no IORDY wait.
    do_access(1'b0, 1'b0, 3'd7, 16'h0000, 16'h1250, 16'h0050, 1'b0, 10);
    // Control-block write; rdata keeps the previous read.
    do_access(1'b1, 1'b1, 3'd6, 16'h0004, 16'h0000, 16'h0050, 1'b0, 10);

    // Data read with IORDY released so the strobe stretches by 5 clocks.
    iordy = 1'b0;
    repeat (3) @(negedge clk);
    fork
      do_access(1'b0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 15);
      begin
        repeat (9) @(negedge clk);
        iordy = 1'b1;
      end
    join

    // IORDY never returns: wait expires after T_TIMEOUT clocks.
    iordy = 1'b0;
    repeat (3) @(negedge clk);
    do_access(1'b0, 1'b0, 3'd1, 16'h0000, 16'hABCD, 16'h00CD, 1'b1, 26);
    iordy = 1'b1;
    repeat (3) @(negedge clk);
    check("timeout_held", timeout, 1);
    fork
      do_access(1'b0, 1'b1, 3'd6, 16'h0000, 16'h1234, 16'h0034, 1'b0, 10);
      begin
        @(negedge clk);
        check("timeout_clear_e0", timeout, 0);
      end
    join

    // req pulses during SETUP and RECOVER must not start or queue an access.
    fork
      do_access(1'b1, 1'b0, 3'd2, 16'hA5A5, 16'h0000, 16'h0034, 1'b0, 10);
      begin
        @(negedge clk);
        #1 req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (7) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("ignored_req_busy", busy, 0);
    check("ignored_req_pending", sb.size(), 0);

    // req held high: second access starts on the edge after done.
    wr = 1'b1; cs3 = 1'b1; addr = 3'd7; wdata = 16'h0F0F; dd_in = 16'hCAFE; req = 1'b1;
    sb.push_back(mk(1'b1, 1'b1, 3'd7, 16'h0F0F, 16'h0034, 1'b0, 10));
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("b2b_first_done", got_done, 1);
    wr = 1'b0; cs3 = 1'b0; addr = 3'd0;
    sb.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0F0F, 16'hCAFE, 1'b0, 10));
    @(negedge clk);
    req = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_idle();

    // Reset during ACTIVE aborts with no done; first req after reset is taken at once.
    wr = 1'b0; cs3 = 1'b0; addr = 3'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_dior_active", dior_, 0);
    reset_ = 1'b0;
    #1;
    check("abort_dior_", dior_, 1);
    check("abort_busy", busy, 0);
    check("abort_cs1fx_", cs1fx_, 1);
    check("abort_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    do_access(1'b0, 1'b0, 3'd5, 16'h0000, 16'h7788, 16'h0088, 1'b0, 10);

    // intrq synchroniser: two-clock delay in each direction.
    intrq = 1'b1;
    @(negedge clk);
    check("intrq_rise_1clk", intrq_s, 0);
    @(negedge clk);
    check("intrq_rise_2clk", intrq_s, 1);
    intrq = 1'b0;
    @(negedge clk);
    check("intrq_fall_1clk", intrq_s, 1);
    @(negedge clk);
    check("intrq_fall_2clk", intrq_s, 0);

    check("dmack_idle", dmack_, 1);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
